ds18b20_emu: RTL and testbench

- 1-Wire slave (responder) that emulates a DS18B20 on the bus: answers reset with a presence pulse, accepts ROM and function commands, and returns scratchpad bytes in read slots.
- Acts as a bench/loopback target for the CPLD's 1-Wire master, and can stand in for a missing sensor on the board.
- Temperature value is supplied by the design on temp_in and is latched by Convert T.

---
 rtl/ds18b20_pkg.sv | 38 +++
 rtl/onewire_crc8.sv | 24 ++
 rtl/ds18b20_emu.sv | 248 ++++++++++++++++++++++++
 tb/tb_ds18b20_emu.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ds18b20_pkg.sv
// Shared types and constants for the DS18B20 1-Wire slave emulator and its CRC helper.
// TX_ROM exists only when DS18B20_EMU_READ_ROM_EN is defined.
package ds18b20_pkg;

  localparam int US_W = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RST_LOW,
    ST_PRES_WAIT,
    ST_PRES,
    ST_ROM_CMD,
    ST_FUNC_CMD,
    ST_TX_SCR,
    ST_CONV,
    ST_IGNORE
`ifdef DS18B20_EMU_READ_ROM_EN
    , ST_TX_ROM
`endif
  } state_t;

  localparam logic [7:0] SKIP_ROM = 8'hCC;
  localparam logic [7:0] READ_SCR = 8'hBE;
  localparam logic [7:0] CONVERT  = 8'h44;
  localparam logic [7:0] READ_ROM = 8'h33;

  localparam logic [7:0] SCR_RES  = 8'hFF;
  localparam logic [7:0] SCR_0C   = 8'h0C;
  localparam logic [7:0] SCR_10   = 8'h10;

  // x^8+x^5+x^4+1 in bit-reversed form, shifted right LSB first
  localparam logic [7:0] CRC_POLY = 8'h8C;

  function automatic logic [US_W-1:0] sat_inc(input logic [US_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/onewire_crc8.sv
// Serial Dallas CRC-8 (reflected, init 0): one data bit per enabled cycle, LSB first.
import ds18b20_pkg::*;

module onewire_crc8 (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clear,
  input  logic       i_en,
  input  logic       i_bit,
  output logic [7:0] o_crc
);

  logic [7:0] r_crc;
  logic       w_fb;

  assign w_fb  = r_crc[0] ^ i_bit;
  assign o_crc = r_crc;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) r_crc <= '0;
    else if (i_en)          r_crc <= (r_crc >> 1) ^ (w_fb ? CRC_POLY : 8'h00);
  end

endmodule

// File: rtl/ds18b20_emu.sv
// DS18B20 1-Wire slave emulator: presence, Skip ROM, Read Scratchpad, Convert T.
// Define DS18B20_EMU_READ_ROM_EN to add Read ROM (8'h33) with a CRC-terminated ROM_CODE.
import ds18b20_pkg::*;

module ds18b20_emu #(
  parameter int         CLK_PER_US   = 10,
  parameter int         RESET_MIN_US = 480,
  parameter int         PRES_WAIT_US = 30,
  parameter int         PRES_LEN_US  = 120,
  parameter int         SAMPLE_US    = 30,
  parameter int         HOLD0_US     = 30,
  parameter int         CONV_US      = 750000,
  parameter logic [7:0] TH_INIT      = 8'h4B,
  parameter logic [7:0] TL_INIT      = 8'h46,
  parameter logic [7:0] CFG_INIT     = 8'h7F
`ifdef DS18B20_EMU_READ_ROM_EN
  , parameter logic [63:0] ROM_CODE  = 64'h00_00_00_00_00_00_01_28
`endif
) (
  input  logic        CLK_10MHZ,
  input  logic        reset,
  inout  wire         oneWirePin,
  input  logic [15:0] temp_in,
  output logic        cmd_strobe,
  output logic [7:0]  last_cmd,
  output logic        converting
);

  localparam int PRE_W  = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int CONV_W = $clog2(CONV_US + 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_PER_US - 1);
  localparam logic [US_W-1:0]   T_RESET   = US_W'(RESET_MIN_US);
  localparam logic [US_W-1:0]   T_PWAIT   = US_W'(PRES_WAIT_US - 1);
  localparam logic [US_W-1:0]   T_PLEN    = US_W'(PRES_LEN_US - 1);
  localparam logic [US_W-1:0]   T_SAMPLE  = US_W'(SAMPLE_US - 1);
  localparam logic [US_W-1:0]   T_HOLD    = US_W'(HOLD0_US - 1);
  localparam logic [CONV_W-1:0] CONV_LOAD = CONV_W'(CONV_US);
  localparam logic [CONV_W-1:0] CONV_ONE  = CONV_W'(1);

  logic [1:0]        r_sync;
  logic              r_line_d, r_pull, r_slot_act, r_hold, r_tx_last;
  logic [PRE_W-1:0]  r_pre;
  logic [US_W-1:0]   r_low_cnt, r_tmr, r_slot_cnt, r_hold_cnt;
  logic [7:0]        r_shift;
  logic [2:0]        r_bit_cnt;
  logic [3:0]        r_byte_idx;
  logic [15:0]       r_temp;
  logic [CONV_W-1:0] r_conv_cnt;
  state_t            r_state;

  logic       w_line, w_fall, w_tick, w_sample, w_reset_seen, w_tx_state;
  logic       w_send, w_tx_bit, w_crc_clr, w_crc_en;
  logic [7:0] w_byte, w_tx_byte, w_crc;
  logic [3:0] w_last_idx;

  assign oneWirePin   = r_pull ? 1'b0 : 1'bz;
  assign w_line       = r_sync[1];
  assign w_fall       = r_line_d & ~w_line;
  assign w_tick       = (r_pre == PRE_LAST);
  assign w_reset_seen = (r_low_cnt >= T_RESET);
  assign w_sample     = r_slot_act && w_tick && (r_slot_cnt == T_SAMPLE);
  assign w_byte       = {w_line, r_shift[7:1]};
  assign w_send       = w_tx_state && w_fall && !r_hold && !r_tx_last;
  assign w_crc_en     = w_send && (r_byte_idx != w_last_idx);
  assign w_tx_bit     = w_tx_byte[r_bit_cnt];

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    w_tx_state = (r_state == ST_TX_SCR);
    w_last_idx = 4'd8;
    w_crc_clr  = w_sample && (r_bit_cnt == 3'd7) && (r_state == ST_FUNC_CMD) && (w_byte == READ_SCR);
    case (r_byte_idx)
      4'd0:    w_tx_byte = r_temp[7:0];
      4'd1:    w_tx_byte = r_temp[15:8];
      4'd2:    w_tx_byte = TH_INIT;
      4'd3:    w_tx_byte = TL_INIT;
      4'd4:    w_tx_byte = CFG_INIT;
      4'd5:    w_tx_byte = SCR_RES;
      4'd6:    w_tx_byte = SCR_0C;
      4'd7:    w_tx_byte = SCR_10;
      4'd8:    w_tx_byte = w_crc;
      default: w_tx_byte = 8'hFF;
    endcase
`ifdef DS18B20_EMU_READ_ROM_EN
    if (w_sample && (r_bit_cnt == 3'd7) && (r_state == ST_ROM_CMD) && (w_byte == READ_ROM))
      w_crc_clr = 1'b1;
    if (r_state == ST_TX_ROM) begin
      w_tx_state = 1'b1;
      w_last_idx = 4'd7;
      w_tx_byte  = (r_byte_idx == 4'd7) ? w_crc : 8'(ROM_CODE >> {r_byte_idx[2:0], 3'b000});
    end
`endif
  end

  onewire_crc8 u_crc (
    .i_clk   (CLK_10MHZ),
    .i_reset (reset),
    .i_clear (w_crc_clr),
    .i_en    (w_crc_en),
    .i_bit   (w_tx_bit),
    .o_crc   (w_crc)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every block sees pre-edge values.
  always_ff @(posedge CLK_10MHZ) begin
    if (reset) begin
      r_sync    <= 2'b11;
      r_line_d  <= 1'b1;
      r_pre     <= '0;
      r_low_cnt <= '0;
    end else begin
      r_sync   <= {r_sync[0], oneWirePin};
      r_line_d <= w_line;
      r_pre    <= w_tick ? '0 : r_pre + 1'b1;
      if (w_line)      r_low_cnt <= '0;
      else if (w_tick) r_low_cnt <= sat_inc(r_low_cnt);
    end
  end

  always_ff @(posedge CLK_10MHZ) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pull     <= 1'b0;
      r_tmr      <= '0;
      r_slot_act <= 1'b0;
      r_slot_cnt <= '0;
      r_hold     <= 1'b0;
      r_hold_cnt <= '0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_byte_idx <= '0;
      r_tx_last  <= 1'b0;
      r_temp     <= 16'h0550;
      r_conv_cnt <= '0;
      converting <= 1'b0;
      cmd_strobe <= 1'b0;
      last_cmd   <= 8'h00;
    end else begin
      cmd_strobe <= 1'b0;
      // The conversion keeps running through bus resets and command traffic.
      if (converting && w_tick) begin
        if (r_conv_cnt == CONV_ONE) begin
          r_temp     <= temp_in;
          converting <= 1'b0;
        end
        r_conv_cnt <= r_conv_cnt - 1'b1;
      end
      if (w_tick)               r_tmr      <= sat_inc(r_tmr);
      if (r_slot_act && w_tick) r_slot_cnt <= sat_inc(r_slot_cnt);
      if (r_hold && w_tick) begin
        r_hold_cnt <= sat_inc(r_hold_cnt);
        if (r_hold_cnt == T_HOLD) begin
          r_hold <= 1'b0;
          r_pull <= 1'b0;
        end
      end

      if (w_reset_seen && (r_state != ST_RST_LOW)) begin
        r_state    <= ST_RST_LOW;
        r_pull     <= 1'b0;
        r_hold     <= 1'b0;
        r_slot_act <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: if (w_fall) r_state <= ST_RST_LOW;
          ST_RST_LOW: if (w_line) begin
            r_tmr   <= '0;
            r_state <= w_reset_seen ? ST_PRES_WAIT : ST_IDLE;
          end
          ST_PRES_WAIT: if (w_tick && (r_tmr == T_PWAIT)) begin
            r_tmr   <= '0;
            r_pull  <= 1'b1;
            r_state <= ST_PRES;
          end
          ST_PRES: if (w_tick && (r_tmr == T_PLEN)) begin
            r_pull     <= 1'b0;
            r_bit_cnt  <= '0;
            r_slot_act <= 1'b0;
            r_state    <= ST_ROM_CMD;
          end
          ST_ROM_CMD, ST_FUNC_CMD: begin
            if (w_fall) begin
              r_slot_act <= 1'b1;
              r_slot_cnt <= '0;
            end else if (w_sample) begin
              r_slot_act <= 1'b0;
              r_shift    <= w_byte;
              r_bit_cnt  <= r_bit_cnt + 1'b1;
              r_byte_idx <= '0;
              r_tx_last  <= 1'b0;
              if (r_bit_cnt == 3'd7) begin
                if (r_state == ST_ROM_CMD) begin
                  r_state <= (w_byte == SKIP_ROM) ? ST_FUNC_CMD : ST_IGNORE;
`ifdef DS18B20_EMU_READ_ROM_EN
                  if (w_byte == READ_ROM) r_state <= ST_TX_ROM;
`endif
                end else begin
                  last_cmd   <= w_byte;
                  cmd_strobe <= 1'b1;
                  if (w_byte == READ_SCR) r_state <= ST_TX_SCR;
                  else if (w_byte == CONVERT) begin
                    r_state    <= ST_CONV;
                    converting <= 1'b1;
                    r_conv_cnt <= CONV_LOAD;
                  end else r_state <= ST_IGNORE;
                end
              end
            end
          end
`ifdef DS18B20_EMU_READ_ROM_EN
          ST_TX_ROM,
`endif
          ST_TX_SCR: begin
            if (r_tx_last) begin
              // Let the final 0 bit finish its hold before leaving the state.
              if (!r_hold) begin
`ifdef DS18B20_EMU_READ_ROM_EN
                r_state <= (r_state == ST_TX_ROM) ? ST_FUNC_CMD : ST_IGNORE;
`else
                r_state <= ST_IGNORE;
`endif
              end
            end else if (w_send) begin
              if (!w_tx_bit) begin
                r_pull     <= 1'b1;
                r_hold     <= 1'b1;
                r_hold_cnt <= '0;
              end
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == 3'd7) begin
                r_byte_idx <= r_byte_idx + 1'b1;
                if (r_byte_idx == w_last_idx) r_tx_last <= 1'b1;
              end
            end
          end
          ST_CONV: if (w_fall && !r_hold && converting) begin
            r_pull     <= 1'b1;
            r_hold     <= 1'b1;
            r_hold_cnt <= '0;
          end
          ST_IGNORE: ;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ds18b20_emu.sv
// Self-checking bench for ds18b20_emu: acts as a 1-Wire master with a pulled-up bus.
`timescale 1ns/1ps
module tb_ds18b20_emu;
  import ds18b20_pkg::*;

  localparam int  CPU      = 4;
  localparam int  CONV_SIM = 100;
  localparam real US_NS    = CPU * 100.0;
  localparam logic [63:0] ROM_CODE_TB = 64'h00_00_00_00_00_00_01_28;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_low;
  logic [15:0] temp_in;
  logic        cmd_strobe;
  logic [7:0]  last_cmd;
  logic        converting;
  wire         ow;

  always #50 clk = ~clk;
  pullup (ow);
  assign ow = m_low ? 1'b0 : 1'bz;

  ds18b20_emu #(
    .CLK_PER_US (CPU),
    .CONV_US    (CONV_SIM)
`ifdef DS18B20_EMU_READ_ROM_EN
    , .ROM_CODE (ROM_CODE_TB)
`endif
  ) dut (
    .CLK_10MHZ  (clk),
    .reset      (reset),
    .oneWirePin (ow),
    .temp_in    (temp_in),
    .cmd_strobe (cmd_strobe),
    .last_cmd   (last_cmd),
    .converting (converting)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] m_temp  = 16'h0550;

  int         strobe_cnt = 0;
  logic [7:0] strobe_cmd = 8'h00;
  realtime    strobe_t   = 0;

  always @(negedge clk) begin
    if (cmd_strobe === 1'b1) begin
      strobe_cnt++;
      strobe_cmd = last_cmd;
      strobe_t   = $realtime;
    end
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic [7:0] crc_bits(input logic [63:0] data, input int nbits);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      logic fb = c[0] ^ data[i];
      c = c >> 1;
      if (fb) c = c ^ 8'h8C;
    end
    return c;
  endfunction

  function automatic logic [7:0] scr_byte(input logic [15:0] t, input int idx);
    logic [63:0] d = {8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, t[15:8], t[7:0]};
    if (idx == 8) return crc_bits(d, 64);
    return 8'(d >> (idx * 8));
  endfunction

  task automatic wait_us(input int n);
    repeat (n * CPU) @(negedge clk);
  endtask

  task automatic bus_low(input int us);
    m_low = 1'b1;
    wait_us(us);
    m_low = 1'b0;
  endtask

  task automatic do_reset();
    bus_low(500);
    wait_us(170);
  endtask

  task automatic write_bit(input logic b);
    m_low = 1'b1;
    wait_us(b ? 2 : 40);
    m_low = 1'b0;
    wait_us(b ? 43 : 5);
  endtask

  task automatic write_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) write_bit(b[i]);
  endtask

  task automatic read_bit(output logic v);
    m_low = 1'b1;
    wait_us(1);
    m_low = 1'b0;
    wait_us(11);
    v = ow;
    wait_us(33);
  endtask

  task automatic read_byte(output logic [7:0] b);
    logic v;
    for (int i = 0; i < 8; i++) begin
      read_bit(v);
      b[i] = v;
    end
  endtask

  task automatic read_and_score(input int n, input string tag);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      read_byte(b);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s byte%0d: got %0h, expected nothing (scoreboard empty)", tag, i, b);
      end else begin
        check($sformatf("%s byte%0d", tag, i), 32'(b), 32'(exp_q.pop_front()));
      end
    end
  endtask

  typedef struct {
    logic [7:0] rom;
    logic       has_func;
    logic [7:0] func;
    int         nread;
    int         exp_strobe;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic v;
    int   cyc, lows, s0, dt;
    logic found;

    vecs.push_back('{8'hCC, 1'b1, 8'hBE, 9, 1, 8'hBE});
    vecs.push_back('{8'hCC, 1'b1, 8'h12, 1, 1, 8'h12});
    vecs.push_back('{8'hF0, 1'b0, 8'h00, 2, 0, 8'h12});
`ifndef DS18B20_EMU_READ_ROM_EN
    vecs.push_back('{8'h33, 1'b0, 8'h00, 1, 0, 8'h12});
`endif

    reset   = 1'b1;
    m_low   = 1'b0;
    temp_in = 16'h0000;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset pin released", 32'(ow), 32'd1);
    check("reset cmd_strobe", 32'(cmd_strobe), 32'd0);
    check("reset last_cmd", 32'(last_cmd), 32'h00);
    check("reset converting", 32'(converting), 32'd0);

    // Short 200 us low: no presence, still idle
    bus_low(200);
    lows = 0;
    for (int i = 0; i < 200 * CPU; i++) begin
      @(negedge clk);
      if (ow !== 1'b1) lows++;
    end
    check("200us low no presence", 32'(lows), 32'd0);
    read_bit(v);
    check("idle read slot", 32'(v), 32'd1);

    // Presence timing after a 500 us reset
    bus_low(500);
    cyc = 0; found = 1'b0;
    for (int i = 0; i < 60 * CPU && !found; i++) begin
      @(negedge clk);
      cyc++;
      if (ow === 1'b0) found = 1'b1;
    end
    check_range("presence delay cycles", found ? cyc : -1, 29 * CPU, 31 * CPU);
    cyc = 0; found = 1'b0;
    for (int i = 0; i < 200 * CPU && !found; i++) begin
      @(negedge clk);
      cyc++;
      if (ow === 1'b1) found = 1'b1;
    end
    check_range("presence length cycles", found ? cyc : -1, 119 * CPU, 121 * CPU);
    wait_us(20);

    // Table-driven command transactions
    for (int k = 0; k < vecs.size(); k++) begin
      do_reset();
      s0 = strobe_cnt;
      write_byte(vecs[k].rom);
      if (vecs[k].has_func) write_byte(vecs[k].func);
      exp_q.delete();
      for (int i = 0; i < vecs[k].nread; i++) begin
        if (vecs[k].rom == SKIP_ROM && vecs[k].has_func && vecs[k].func == READ_SCR)
          exp_q.push_back(scr_byte(m_temp, i));
        else
          exp_q.push_back(8'hFF);
      end
      read_and_score(vecs[k].nread, $sformatf("vec%0d", k));
      check($sformatf("vec%0d strobe count", k), 32'(strobe_cnt - s0), 32'(vecs[k].exp_strobe));
      check($sformatf("vec%0d last_cmd", k), 32'(last_cmd), 32'(vecs[k].exp_last));
    end

    // Reset in the middle of a scratchpad transmit
    do_reset();
    write_byte(SKIP_ROM);
    write_byte(READ_SCR);
    for (int i = 0; i < 3; i++) begin
      read_bit(v);
      check($sformatf("midtx bit%0d", i), 32'(v), 32'(scr_byte(m_temp, 0) >> i) & 32'd1);
    end
    bus_low(500);
    wait_us(2);
    check("midtx pin released", 32'(ow), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 40 * CPU && !found; i++) begin
      @(negedge clk);
      if (ow === 1'b0) found = 1'b1;
    end
    check("midtx presence seen", 32'(found), 32'd1);
    wait_us(140);
    write_byte(SKIP_ROM);
    write_byte(READ_SCR);
    exp_q.delete();
    exp_q.push_back(scr_byte(m_temp, 0));
    exp_q.push_back(scr_byte(m_temp, 1));
    read_and_score(2, "midtx retry");

    // Convert T
    temp_in = 16'h0191;
    do_reset();
    s0 = strobe_cnt;
    write_byte(SKIP_ROM);
    write_byte(CONVERT);
    check("conv strobe count", 32'(strobe_cnt - s0), 32'd1);
    check("conv strobe last_cmd", 32'(strobe_cmd), 32'h44);
    check("conv converting high", 32'(converting), 32'd1);
    for (int i = 0; i < 6; i++) begin
      dt = int'(($realtime - strobe_t) / US_NS);
      read_bit(v);
      if (dt <= CONV_SIM - 4)      check($sformatf("conv slot at %0dus", dt), 32'(v), 32'd0);
      else if (dt >= CONV_SIM + 3) check($sformatf("conv slot at %0dus", dt), 32'(v), 32'd1);
    end
    check("conv converting low", 32'(converting), 32'd0);
    m_temp = 16'h0191;
    do_reset();
    write_byte(SKIP_ROM);
    write_byte(READ_SCR);
    exp_q.delete();
    exp_q.push_back(scr_byte(m_temp, 0));
    exp_q.push_back(scr_byte(m_temp, 1));
    read_and_score(2, "conv temp");

`ifdef DS18B20_EMU_READ_ROM_EN
    do_reset();
    write_byte(READ_ROM);
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'(ROM_CODE_TB >> (i * 8)));
    exp_q.push_back(crc_bits(ROM_CODE_TB, 56));
    read_and_score(8, "rom");
    write_byte(READ_SCR);
    exp_q.push_back(scr_byte(m_temp, 0));
    exp_q.push_back(scr_byte(m_temp, 1));
    read_and_score(2, "rom then scr");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
